// File: rtl/bp_me_pkg.sv
// Shared types and constants for the host I/O slice: BedRock mem header
// layout, MMIO offsets and the slice FSM state encoding.
package bp_me_pkg;

  localparam int paddr_width_gp  = 40;
  localparam int lce_id_width_gp = 4;
  localparam int did_width_gp    = 3;
  localparam int way_id_width_gp = 3;

  localparam logic [19:0] bp_host_putchar_offset_gp = 20'h0_1000;
  localparam logic [19:0] bp_host_finish_offset_gp  = 20'h0_2000;
  localparam logic [19:0] bp_host_scratch_offset_gp = 20'h0_3000;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011,
    e_bedrock_mem_pre   = 4'b0100,
    e_bedrock_mem_amo   = 4'b0101
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'b000,
    e_bedrock_msg_size_2   = 3'b001,
    e_bedrock_msg_size_4   = 3'b010,
    e_bedrock_msg_size_8   = 3'b011,
    e_bedrock_msg_size_16  = 3'b100,
    e_bedrock_msg_size_32  = 3'b101,
    e_bedrock_msg_size_64  = 3'b110,
    e_bedrock_msg_size_128 = 3'b111
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [did_width_gp-1:0]    did;
    logic [way_id_width_gp-1:0] way_id;
    logic [lce_id_width_gp-1:0] lce_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s    payload;
    bp_bedrock_msg_size_e       size;
    logic [paddr_width_gp-1:0]  addr;
    logic [3:0]                 subop;
    bp_bedrock_mem_type_e       msg_type;
  } bp_bedrock_mem_fwd_header_s;

  // Responses carry the request header back unchanged
  typedef bp_bedrock_mem_fwd_header_s bp_bedrock_mem_rev_header_s;

  typedef enum logic [2:0] {
    e_ready, e_drain, e_exec, e_char, e_rev
  } bp_me_host_io_state_e;

  // Register effect of a write: keep the low 1/2/4 bytes, anything wider is 8
  function automatic logic [63:0] bp_size_mask(bp_bedrock_msg_size_e size, logic [63:0] d);
    case (size)
      e_bedrock_msg_size_1: return {56'b0, d[7:0]};
      e_bedrock_msg_size_2: return {48'b0, d[15:0]};
      e_bedrock_msg_size_4: return {32'b0, d[31:0]};
      default:              return d;
    endcase
  endfunction

endpackage

// File: rtl/bp_me_stream_beat_counter.sv
// Set/down beat counter for one BedRock stream. last_o marks the beat
// currently being handshaked as the final beat of the message.
module bp_me_stream_beat_counter
  import bp_me_pkg::*;
#(
  parameter int bedrock_fill_width_p = 64
)(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  bp_bedrock_msg_size_e size_i,
  input  logic                 set_i,
  input  logic                 down_i,
  output logic                 multi_o,
  output logic                 last_o
);

  localparam int lg_fill_bytes_lp = $clog2(bedrock_fill_width_p / 8);
  localparam int max_beats_lp     = (1024 / bedrock_fill_width_p) > 1 ? (1024 / bedrock_fill_width_p) : 1;
  localparam int cnt_width_lp     = $clog2(max_beats_lp) + 1;

  logic [cnt_width_lp-1:0] cnt_r, beats_m1;

  // beats-1 for the incoming size; single beat whenever the message fits one fill
  always_comb begin
    beats_m1 = '0;
    if (int'(size_i) > lg_fill_bytes_lp)
      beats_m1 = cnt_width_lp'((1 << (int'(size_i) - lg_fill_bytes_lp)) - 1);
  end

  assign multi_o = (beats_m1 != '0);
  assign last_o  = (cnt_r == '0);

  // A set that coincides with a beat transfer (fwd beat 0) already consumes one beat
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      cnt_r <= '0;
    else if (set_i)
      cnt_r <= (down_i && multi_o) ? beats_m1 - 1'b1 : beats_m1;
    else if (down_i && cnt_r != '0)
      cnt_r <= cnt_r - 1'b1;
  end

endmodule

// File: rtl/bp_me_host_io_slice.sv
// Host-side I/O terminator: decodes putchar / finish / scratch MMIO from the
// mem_fwd stream and returns a well-formed mem_rev stream.
module bp_me_host_io_slice
  import bp_me_pkg::*;
#(
  parameter int          bedrock_fill_width_p = 64,
  parameter logic [19:0] putchar_offset_p     = bp_host_putchar_offset_gp,
  parameter logic [19:0] finish_offset_p      = bp_host_finish_offset_gp,
  parameter logic [19:0] scratch_offset_p     = bp_host_scratch_offset_gp
)(
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  bp_bedrock_mem_fwd_header_s      mem_fwd_header_i,
  input  logic [bedrock_fill_width_p-1:0] mem_fwd_data_i,
  input  logic                            mem_fwd_v_i,
  output logic                            mem_fwd_ready_and_o,
  output bp_bedrock_mem_rev_header_s      mem_rev_header_o,
  output logic [bedrock_fill_width_p-1:0] mem_rev_data_o,
  output logic                            mem_rev_v_o,
  input  logic                            mem_rev_ready_and_i,
  output logic [7:0]                      char_o,
  output logic                            char_v_o,
  input  logic                            char_ready_and_i,
  output logic                            finish_o,
  output logic [7:0]                      finish_code_o
);

  bp_me_host_io_state_e state_r, state_n;
  bp_bedrock_mem_fwd_header_s hdr_r;
  logic [63:0] data_r, scratch_r;
  logic [bedrock_fill_width_p-1:0] rev_data_r;
  logic fwd_ready, fwd_accept, rev_accept;
  logic fwd_multi, fwd_last, rev_last, rev_unused_multi;
  logic is_wr, hit_putchar, hit_finish, hit_scratch;
  bp_bedrock_msg_size_e rev_size;

  // Anything not a write is answered like a read
  assign is_wr       = (hdr_r.msg_type == e_bedrock_mem_wr) || (hdr_r.msg_type == e_bedrock_mem_uc_wr);
  assign hit_putchar = (hdr_r.addr[19:0] == putchar_offset_p);
  assign hit_finish  = (hdr_r.addr[19:0] == finish_offset_p);
  assign hit_scratch = (hdr_r.addr[19:0] == scratch_offset_p);
  assign rev_size    = is_wr ? e_bedrock_msg_size_1 : hdr_r.size;

  assign mem_fwd_ready_and_o = fwd_ready & ~reset_i;
  assign fwd_accept          = mem_fwd_v_i & mem_fwd_ready_and_o;
  assign rev_accept          = mem_rev_v_o & mem_rev_ready_and_i;

  bp_me_stream_beat_counter #(.bedrock_fill_width_p(bedrock_fill_width_p)) fwd_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .size_i(mem_fwd_header_i.size),
    .set_i(state_r == e_ready && fwd_accept), .down_i(fwd_accept),
    .multi_o(fwd_multi), .last_o(fwd_last)
  );

  bp_me_stream_beat_counter #(.bedrock_fill_width_p(bedrock_fill_width_p)) rev_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .size_i(rev_size),
    .set_i(state_r == e_exec), .down_i(rev_accept),
    .multi_o(rev_unused_multi), .last_o(rev_last)
  );

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n     = state_r;
    fwd_ready   = 1'b0;
    mem_rev_v_o = 1'b0;
    char_v_o    = 1'b0;
    case (state_r)
      e_ready: begin
        fwd_ready = 1'b1;
        if (mem_fwd_v_i) state_n = fwd_multi ? e_drain : e_exec;
      end
      e_drain: begin
        fwd_ready = 1'b1;
        if (mem_fwd_v_i && fwd_last) state_n = e_exec;
      end
      e_exec:  state_n = (is_wr && hit_putchar) ? e_char : e_rev;
      e_char: begin
        char_v_o = 1'b1;
        if (char_ready_and_i) state_n = e_rev;
      end
      e_rev: begin
        mem_rev_v_o = 1'b1;
        if (mem_rev_ready_and_i && rev_last) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  // Request capture, register effects and response data
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_r         <= '0;
      data_r        <= '0;
      scratch_r     <= '0;
      rev_data_r    <= '0;
      finish_o      <= 1'b0;
      finish_code_o <= '0;
    end else begin
      if (state_r == e_ready && fwd_accept) begin
        hdr_r  <= mem_fwd_header_i;
        data_r <= mem_fwd_data_i[63:0];
      end
      if (state_r == e_exec) begin
        rev_data_r <= '0;
        if (is_wr) begin
          if (hit_finish) begin
            finish_o      <= 1'b1;
            finish_code_o <= data_r[7:0];
          end
          if (hit_scratch) scratch_r <= bp_size_mask(hdr_r.size, data_r);
        end else if (hit_scratch) begin
          rev_data_r <= bedrock_fill_width_p'(scratch_r);
        end
      end
      // Only beat 0 of a read carries the value
      if (rev_accept) rev_data_r <= '0;
    end
  end

  assign mem_rev_header_o = hdr_r;
  assign mem_rev_data_o   = rev_data_r;
  assign char_o           = data_r[7:0];

endmodule

// File: tb/tb_bp_me_host_io_slice.sv
// Scoreboard bench for the host I/O slice: expected rev beats are queued as
// requests are driven and checked as the DUT hands them over.
module tb_bp_me_host_io_slice;
  import bp_me_pkg::*;

  typedef struct {
    bp_bedrock_mem_rev_header_s h;
    logic [63:0] d;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0;
  bp_bedrock_mem_fwd_header_s fwd_hdr;
  logic [63:0] fwd_data;
  logic fwd_v, fwd_ready;
  bp_bedrock_mem_rev_header_s rev_hdr;
  logic [63:0] rev_data;
  logic rev_v, rev_ready;
  logic [7:0] char_o, finish_code;
  logic char_v, char_ready, finish;

  int errors = 0, checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bp_me_host_io_slice dut (
    .clk_i(clk), .reset_i(rst),
    .mem_fwd_header_i(fwd_hdr), .mem_fwd_data_i(fwd_data),
    .mem_fwd_v_i(fwd_v), .mem_fwd_ready_and_o(fwd_ready),
    .mem_rev_header_o(rev_hdr), .mem_rev_data_o(rev_data),
    .mem_rev_v_o(rev_v), .mem_rev_ready_and_i(rev_ready),
    .char_o(char_o), .char_v_o(char_v), .char_ready_and_i(char_ready),
    .finish_o(finish), .finish_code_o(finish_code)
  );

  // Scoreboard: every rev handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && rev_v && rev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rev_unexpected: got hdr=%h data=%h, required no beat", rev_hdr, rev_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rev_hdr, rev_data} !== {e.h, e.d}) begin
          errors++;
          $display("FAIL rev_beat: got hdr=%h data=%h, required hdr=%h data=%h", rev_hdr, rev_data, e.h, e.d);
        end
      end
    end
  end

  function automatic bp_bedrock_mem_fwd_header_s mk(bp_bedrock_mem_type_e t, logic [19:0] off,
                                                    bp_bedrock_msg_size_e s, logic [3:0] lce);
    bp_bedrock_mem_fwd_header_s h;
    h = '0;
    h.msg_type       = t;
    h.addr           = {20'h00800, off};
    h.size           = s;
    h.payload.lce_id = lce;
    h.payload.did    = 3'd2;
    return h;
  endfunction

  task automatic push(input bp_bedrock_mem_fwd_header_s h, input logic [63:0] d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.h = h;
      e.d = (i == 0) ? d : 64'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input bp_bedrock_mem_fwd_header_s h, input logic [63:0] d0, input int nb);
    int t;
    for (int b = 0; b < nb; b++) begin
      fwd_hdr  = h;
      fwd_data = (b == 0) ? d0 : {$urandom, $urandom};
      fwd_v    = 1'b1;
      t = 0;
      @(negedge clk);
      while (!fwd_ready && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (fwd_ready !== 1'b1) begin
        errors++;
        $display("FAIL fwd_accept beat %0d: ready=%b, required 1", b, fwd_ready);
      end
      @(posedge clk); #1;
    end
    fwd_v = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && fwd_ready) && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0 || fwd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: pending=%0d ready=%b, required 0 and 1", name, exp_q.size(), fwd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_reset(input string name);
    checks++;
    if ({fwd_ready, rev_v, char_v, finish, finish_code} !== 12'h0) begin
      errors++;
      $display("FAIL %s: fwd_ready=%b rev_v=%b char_v=%b finish=%b code=%h, required all 0",
               name, fwd_ready, rev_v, char_v, finish, finish_code);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fwd_v = 1'b0; fwd_hdr = '0; fwd_data = '0; rev_ready = 1'b1; char_ready = 1'b1;
    #1 check_outputs_reset("reset_hold");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_ready !== 1'b1) begin errors++; $display("FAIL reset_release: fwd_ready=%b, required 1", fwd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_putchar();
    bp_bedrock_mem_fwd_header_s h;
    int t;
    h = mk(e_bedrock_mem_uc_wr, bp_host_putchar_offset_gp, e_bedrock_msg_size_1, 4'd1);
    char_ready = 1'b0;
    push(h, 64'h0, 1);
    send(h, 64'h41, 1);
    t = 0;
    while (!char_v && t < 20) begin @(negedge clk); t++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (char_v !== 1'b1 || char_o !== 8'h41 || rev_v !== 1'b0) begin
        errors++;
        $display("FAIL putchar_hold %0d: char_v=%b char=%h rev_v=%b, required 1 41 0", i, char_v, char_o, rev_v);
      end
    end
    @(posedge clk); #1 char_ready = 1'b1;
    wait_idle("putchar");
  endtask

  task automatic test_scratch();
    bp_bedrock_mem_fwd_header_s h;
    h = mk(e_bedrock_mem_uc_wr, bp_host_scratch_offset_gp, e_bedrock_msg_size_8, 4'd3);
    push(h, 64'h0, 1);
    send(h, 64'hDEAD_BEEF_0123_4567, 1);
    // accept edge was cycle 0; cycle 1 is exec, cycle 2 shows the response
    @(negedge clk);
    checks++;
    if (rev_v !== 1'b0) begin errors++; $display("FAIL latency_c1: rev_v=%b, required 0", rev_v); end
    @(negedge clk);
    checks++;
    if (rev_v !== 1'b1) begin errors++; $display("FAIL latency_c2: rev_v=%b, required 1", rev_v); end
    wait_idle("scratch_wr8");
    h = mk(e_bedrock_mem_uc_rd, bp_host_scratch_offset_gp, e_bedrock_msg_size_8, 4'd5);
    push(h, 64'hDEAD_BEEF_0123_4567, 1);
    send(h, 64'h0, 1);
    wait_idle("scratch_rd8");
    h = mk(e_bedrock_mem_uc_wr, bp_host_scratch_offset_gp, e_bedrock_msg_size_2, 4'd3);
    push(h, 64'h0, 1);
    send(h, 64'hFFFF_FFFF_FFFF_AAAA, 1);
    wait_idle("scratch_wr2");
    h = mk(e_bedrock_mem_uc_rd, bp_host_scratch_offset_gp, e_bedrock_msg_size_8, 4'd6);
    push(h, 64'h0000_0000_0000_AAAA, 1);
    send(h, 64'h0, 1);
    wait_idle("scratch_rd_masked");
  endtask

  task automatic test_multibeat();
    bp_bedrock_mem_fwd_header_s h;
    h = mk(e_bedrock_mem_wr, bp_host_scratch_offset_gp, e_bedrock_msg_size_64, 4'd2);
    push(h, 64'h0, 1);
    send(h, 64'h1111_2222_3333_4444, 8);
    wait_idle("multi_wr");
    h = mk(e_bedrock_mem_rd, bp_host_scratch_offset_gp, e_bedrock_msg_size_64, 4'd7);
    push(h, 64'h1111_2222_3333_4444, 8);
    send(h, 64'h0, 8);
    wait_idle("multi_rd");
  endtask

  task automatic test_finish();
    bp_bedrock_mem_fwd_header_s h;
    h = mk(e_bedrock_mem_uc_wr, bp_host_finish_offset_gp, e_bedrock_msg_size_1, 4'd0);
    push(h, 64'h0, 1);
    send(h, 64'h03, 1);
    wait_idle("finish1");
    checks++;
    if (finish !== 1'b1 || finish_code !== 8'h03) begin
      errors++; $display("FAIL finish_first: finish=%b code=%h, required 1 03", finish, finish_code);
    end
    push(h, 64'h0, 1);
    send(h, 64'h00, 1);
    wait_idle("finish2");
    checks++;
    if (finish !== 1'b1 || finish_code !== 8'h00) begin
      errors++; $display("FAIL finish_second: finish=%b code=%h, required 1 00", finish, finish_code);
    end
  endtask

  task automatic test_unmapped_stall();
    bp_bedrock_mem_fwd_header_s h;
    bp_bedrock_mem_rev_header_s ph;
    logic [63:0] pd;
    logic stalled;
    int t;
    h = mk(e_bedrock_mem_uc_rd, 20'h0_4000, e_bedrock_msg_size_32, 4'd9);
    rev_ready = 1'b0;
    push(h, 64'h0, 4);
    send(h, 64'h5555, 4);
    stalled = 1'b0; ph = '0; pd = '0; t = 0;
    while (t < 40 && !(exp_q.size() == 0 && fwd_ready)) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (rev_v !== 1'b1 || rev_hdr !== ph || rev_data !== pd) begin
          errors++;
          $display("FAIL stall_stable: v=%b hdr=%h data=%h, required 1 %h %h", rev_v, rev_hdr, rev_data, ph, pd);
        end
      end
      stalled = rev_v && !rev_ready;
      ph = rev_hdr; pd = rev_data;
      @(posedge clk); #1 rev_ready = ~rev_ready;
      t++;
    end
    rev_ready = 1'b1;
    wait_idle("unmapped_rd");
  endtask

  task automatic test_reset_mid_drain();
    bp_bedrock_mem_fwd_header_s h;
    h = mk(e_bedrock_mem_wr, bp_host_scratch_offset_gp, e_bedrock_msg_size_32, 4'd4);
    fwd_hdr = h; fwd_data = 64'h1234; fwd_v = 1'b1;
    @(posedge clk); #1;
    fwd_data = 64'h9999;
    @(negedge clk);
    checks++;
    if (fwd_ready !== 1'b1 || rev_v !== 1'b0) begin
      errors++; $display("FAIL drain_ready: fwd_ready=%b rev_v=%b, required 1 0", fwd_ready, rev_v);
    end
    @(posedge clk); #3 rst = 1'b1;
    #1 check_outputs_reset("reset_mid_drain");
    fwd_v = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: fwd_ready=%b, required 1", fwd_ready); end
    @(posedge clk); #1;
    h = mk(e_bedrock_mem_uc_rd, bp_host_scratch_offset_gp, e_bedrock_msg_size_8, 4'd8);
    push(h, 64'h0, 1);
    send(h, 64'h0, 1);
    wait_idle("post_reset_rd");
  endtask

  initial begin
    test_reset();
    test_putchar();
    test_scratch();
    test_multibeat();
    test_finish();
    test_unmapped_stall();
    test_reset_mid_drain();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
